// File: rtl/proc_pkg.sv
// Shared pipeline definitions: instruction field encodings for the multiply/divide
// path, the status register number and codes written on an exception, and the
// sequencer state type.
package proc_pkg;

  localparam logic [4:0] OPC_ALU  = 5'b00000;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Writeback target and payload used when the unit reports overflow / divide error
  localparam logic [4:0]  RSTATUS  = 5'd30;
  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/mdop_decode.sv
// Combinational decode of the D/X instruction into mult/div flags and the
// destination register. Also used by the stall and bypass logic.
module mdop_decode
  import proc_pkg::*;
(
  input  logic [31:0] dx_ir,
  output logic        is_mult,
  output logic        is_div,
  output logic [4:0]  rd
);

  logic alu_opc;
  logic unused_ir;

  assign alu_opc   = (dx_ir[31:27] == OPC_ALU);
  assign is_mult   = alu_opc && (dx_ir[6:2] == ALU_MULT);
  assign is_div    = alu_opc && (dx_ir[6:2] == ALU_DIV);
  assign rd        = dx_ir[26:22];
  // Source register and shamt fields are not needed to sequence the unit
  assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

endmodule

// File: rtl/multdiv_seq.sv
// Sequencer for the shared multi-cycle multiply/divide unit.
// Decodes mult/div in D/X, fires one start pulse, stalls F/D/X until the unit
// completes, then presents the result (or exception status) to writeback for
// exactly one cycle.
//
// Handshake: md_ctrl_mult/md_ctrl_div are single-cycle start strobes issued in
// the first BUSY cycle; md_op_a/md_op_b are held from that strobe until
// completion. md_ready is a single-cycle completion strobe and is only honoured
// in BUSY (it may coincide with the start strobe). pw_valid is a single-cycle
// writeback strobe qualifying pw_rd/pw_data; there is no back-pressure.
//
// Optional watchdog: define MULTDIV_TIMEOUT_EN to force completion with an
// exception after MAX_CYCLES busy cycles without md_ready.
module multdiv_seq
  import proc_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] dx_ir,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        pw_stall,
  output logic        pw_valid,
  output logic [4:0]  pw_rd,
  output logic [31:0] pw_data,
  output md_state_t   dbg_state
);

  if ((1 << CNT_W) <= MAX_CYCLES) begin : g_cnt_w_check
    $error("multdiv_seq: CNT_W too narrow to hold MAX_CYCLES");
  end

  logic       dec_is_mult;
  logic       dec_is_div;
  logic [4:0] dec_rd;
  logic       md_op;

  mdop_decode u_decode (
    .dx_ir   (dx_ir),
    .is_mult (dec_is_mult),
    .is_div  (dec_is_div),
    .rd      (dec_rd)
  );

  assign md_op = dec_is_mult | dec_is_div;

  md_state_t   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        ctrl_mult_q, ctrl_mult_d;
  logic        ctrl_div_q, ctrl_div_d;
  logic        pw_valid_q, pw_valid_d;
  logic [4:0]  pw_rd_q, pw_rd_d;
  logic [31:0] pw_data_q, pw_data_d;

  logic        timeout;
  logic        finish;
  logic        exc_sel;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Busy-cycle counter: zero outside BUSY, counts up while waiting
  always_comb begin
    cnt_d = '0;
    if (state_q == MD_BUSY) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CNT_MAX);
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output logic of the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    is_div_d    = is_div_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    pw_valid_d  = 1'b0;
    pw_rd_d     = '0;
    pw_data_d   = '0;
    finish      = 1'b0;
    exc_sel     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_op) begin
          rd_d        = dec_rd;
          is_div_d    = dec_is_div;
          op_a_d      = data_a;
          op_b_d      = data_b;
          ctrl_mult_d = dec_is_mult;
          ctrl_div_d  = dec_is_div;
          state_d     = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A completion in the same cycle as the watchdog takes priority
        if (md_ready) begin
          finish  = 1'b1;
          exc_sel = md_exception;
        end else if (timeout) begin
          finish  = 1'b1;
          exc_sel = 1'b1;
        end
        if (finish) begin
          state_d    = MD_DONE;
          pw_valid_d = 1'b1;
          pw_rd_d    = exc_sel ? RSTATUS : rd_q;
          pw_data_d  = exc_sel ? (is_div_q ? EXC_DIV : EXC_MULT) : md_result;
        end
      end
      // The stalled instruction advances on this edge; decode is not looked at
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State and output registers; synchronous clear on reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= MD_IDLE;
      rd_q        <= '0;
      is_div_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      pw_valid_q  <= 1'b0;
      pw_rd_q     <= '0;
      pw_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      is_div_q    <= is_div_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      pw_valid_q  <= pw_valid_d;
      pw_rd_q     <= pw_rd_d;
      pw_data_q   <= pw_data_d;
    end
  end

  // Stall is combinational in IDLE so the decoding instruction is held at once;
  // gated by reset so every output reads 0 while reset is applied.
  assign pw_stall     = reset_n & (((state_q == MD_IDLE) & md_op) | (state_q == MD_BUSY));
  assign md_ctrl_mult = ctrl_mult_q;
  assign md_ctrl_div  = ctrl_div_q;
  assign md_op_a      = op_a_q;
  assign md_op_b      = op_b_q;
  assign pw_valid     = pw_valid_q;
  assign pw_rd        = pw_rd_q;
  assign pw_data      = pw_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: back-to-back mult/div vector table, long
// latency (or watchdog when MULTDIV_TIMEOUT_EN is defined), non-mult/div
// instructions, and reset in the middle of an operation.
module tb_multdiv_seq;
  import proc_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] dx_ir, data_a, data_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_op_a, md_op_b;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic        pw_stall, pw_valid;
  logic [4:0]  pw_rd;
  logic [31:0] pw_data;
  md_state_t   dbg_state;

  always #5 clock = ~clock;

  multdiv_seq #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .dx_ir        (dx_ir),
    .data_a       (data_a),
    .data_b       (data_b),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_op_a      (md_op_a),
    .md_op_b      (md_op_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .pw_stall     (pw_stall),
    .pw_valid     (pw_valid),
    .pw_rd        (pw_rd),
    .pw_data      (pw_data),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // {rd, data} expected at each writeback strobe, in order
  logic [36:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ir(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
    logic        is_div;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } md_vec_t;

  function automatic md_vec_t mk(input string name, input logic [31:0] ir, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res, input logic exc,
                                 input int lat, input logic is_div, input logic [4:0] exp_rd,
                                 input logic [31:0] exp_data);
    md_vec_t v;
    v.name = name; v.ir = ir; v.a = a; v.b = b; v.res = res; v.exc = exc;
    v.lat = lat; v.is_div = is_div; v.exp_rd = exp_rd; v.exp_data = exp_data;
    return v;
  endfunction

  // ---------------- scoreboard on the writeback strobe ----------------
  always @(negedge clock) begin
    if (pw_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rd=%0d data=%0h expected no writeback", pw_rd, pw_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("writeback", {27'd0, pw_rd, pw_data}, {27'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One mult/div from D/X entry to the DONE cycle. Leaves the instruction in
  // D/X during DONE so a retrigger would show up in the next window.
  task automatic do_md(input md_vec_t v);
    int mp, dp, st;
    mp = 0; dp = 0; st = 0;
    @(posedge clock); #1;
    dx_ir = v.ir; data_a = v.a; data_b = v.b;
    exp_q.push_back({v.exp_rd, v.exp_data});
    @(negedge clock);
    mp += int'(md_ctrl_mult); dp += int'(md_ctrl_div); st += int'(pw_stall);
    check({v.name, "_stall_t"}, {63'd0, pw_stall}, 64'd1);
    for (int c = 0; c <= v.lat; c++) begin
      @(posedge clock); #1;
      md_ready = (c == v.lat);
      md_result = v.res;
      md_exception = v.exc;
      if (c == 0) begin
        data_a = ~v.a;
        data_b = ~v.b;
      end
      @(negedge clock);
      mp += int'(md_ctrl_mult); dp += int'(md_ctrl_div); st += int'(pw_stall);
      if (c == 0) begin
        check({v.name, "_start"}, {62'd0, md_ctrl_mult, md_ctrl_div}, {62'd0, !v.is_div, v.is_div});
      end
      check({v.name, "_ops"}, {md_op_a, md_op_b}, {v.a, v.b});
    end
    @(posedge clock); #1;
    md_ready = 1'b0; md_result = '0; md_exception = 1'b0;
    @(negedge clock);
    mp += int'(md_ctrl_mult); dp += int'(md_ctrl_div); st += int'(pw_stall);
    check({v.name, "_done_valid"}, {63'd0, pw_valid}, 64'd1);
    check({v.name, "_done_state"}, {62'd0, dbg_state}, {62'd0, MD_DONE});
    check({v.name, "_mult_pulses"}, 64'(mp), v.is_div ? 64'd0 : 64'd1);
    check({v.name, "_div_pulses"}, 64'(dp), v.is_div ? 64'd1 : 64'd0);
    check({v.name, "_stall_cycles"}, 64'(st), 64'(v.lat + 2));
  endtask

  // Unit never answers; the watchdog must close the operation at t+42
  task automatic do_timeout(input string name, input logic [31:0] ir, input logic [31:0] code);
    int n;
    bit seen;
    n = 0; seen = 0;
    @(posedge clock); #1;
    dx_ir = ir; data_a = 32'd11; data_b = 32'd13;
    exp_q.push_back({5'd30, code});
    while (!seen && n < 100) begin
      @(negedge clock);
      if (pw_valid === 1'b1) seen = 1;
      else n++;
    end
    check({name, "_seen"}, {63'd0, seen}, 64'd1);
    check({name, "_cycles"}, 64'(n), 64'd42);
  endtask

  // Apply bus idle, check the post-DONE cycle for a retrigger pulse
  task automatic idle_after(input string name);
    @(posedge clock); #1;
    dx_ir = 32'd0;
    @(negedge clock);
    check({name, "_no_retrigger"}, {62'd0, md_ctrl_mult, md_ctrl_div}, 64'd0);
    check({name, "_idle"}, {62'd0, dbg_state}, {62'd0, MD_IDLE});
  endtask

  md_vec_t     md_vecs[7];
  logic [31:0] other_ir[5];
  string       other_nm[5];

  initial begin
    // Back-to-back table: each entry enters D/X on the edge that ends the previous DONE
    md_vecs[0] = mk("mult_7x6",  r_ir(5'd3, 5'd1, 5'd2, ALU_MULT), 32'd7, 32'd6, 32'd42, 1'b0, 17, 1'b0, 5'd3, 32'd42);
    md_vecs[1] = mk("div_by0",   r_ir(5'd5, 5'd4, 5'd0, ALU_DIV), 32'd100, 32'd0, 32'hdeadbeef, 1'b1, 3, 1'b1, 5'd30, 32'd5);
    md_vecs[2] = mk("div_100_7", r_ir(5'd9, 5'd7, 5'd8, ALU_DIV), 32'd100, 32'd7, 32'd14, 1'b0, 5, 1'b1, 5'd9, 32'd14);
    md_vecs[3] = mk("mult_ovf",  r_ir(5'd4, 5'd1, 5'd2, ALU_MULT), 32'h7fffffff, 32'd2, 32'hfffffffe, 1'b1, 2, 1'b0, 5'd30, 32'd4);
    md_vecs[4] = mk("mult_lat0", r_ir(5'd6, 5'd1, 5'd2, ALU_MULT), 32'd3, 32'd5, 32'd15, 1'b0, 0, 1'b0, 5'd6, 32'd15);
    md_vecs[5] = mk("mult_rd0",  r_ir(5'd0, 5'd1, 5'd2, ALU_MULT), 32'd3, 32'd3, 32'd9, 1'b0, 1, 1'b0, 5'd0, 32'd9);
    md_vecs[6] = mk("div_neg",   r_ir(5'd31, 5'd1, 5'd2, ALU_DIV), 32'hffffffec, 32'd3, 32'hfffffffa, 1'b0, 4, 1'b1, 5'd31, 32'hfffffffa);

    other_nm[0] = "lw";        other_ir[0] = {5'b01000, 5'd3, 5'd1, 17'd4};
    other_nm[1] = "addi";      other_ir[1] = {5'b00101, 5'd2, 5'd1, 17'd10};
    other_nm[2] = "add";       other_ir[2] = r_ir(5'd4, 5'd1, 5'd2, 5'b00000);
    other_nm[3] = "addi_imm6"; other_ir[3] = {5'b00101, 5'd3, 5'd1, 10'd0, ALU_MULT, 2'b00};
    other_nm[4] = "alu_op8";   other_ir[4] = r_ir(5'd4, 5'd1, 5'd2, 5'b01000);

    reset_n = 1'b0;
    dx_ir = '0; data_a = '0; data_b = '0;
    md_result = '0; md_exception = 1'b0; md_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_state", {62'd0, dbg_state}, {62'd0, MD_IDLE});
    check("rst_ctrl", {60'd0, md_ctrl_mult, md_ctrl_div, pw_stall, pw_valid}, 64'd0);
    check("rst_ops", {md_op_a, md_op_b}, 64'd0);
    check("rst_wb", {27'd0, pw_rd, pw_data}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) do_md(md_vecs[i]);
    idle_after("table");

`ifdef MULTDIV_TIMEOUT_EN
    do_timeout("timeout_mult", r_ir(5'd3, 5'd1, 5'd2, ALU_MULT), 32'd4);
    idle_after("timeout_mult");
    do_timeout("timeout_div", r_ir(5'd8, 5'd1, 5'd2, ALU_DIV), 32'd5);
    idle_after("timeout_div");
`else
    // Without the watchdog the sequencer waits well past MAX_CYCLES
    do_md(mk("mult_lat60", r_ir(5'd7, 5'd1, 5'd2, ALU_MULT), 32'd2, 32'd3, 32'd6, 1'b0, 60, 1'b0, 5'd7, 32'd6));
    idle_after("long");
`endif

    // Instructions that must not touch the unit
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      dx_ir = other_ir[i];
      @(negedge clock);
      check({other_nm[i], "_stall"}, {63'd0, pw_stall}, 64'd0);
      @(posedge clock); #1;
      @(negedge clock);
      check({other_nm[i], "_nostart"}, {62'd0, md_ctrl_mult, md_ctrl_div}, 64'd0);
      check({other_nm[i], "_state"}, {62'd0, dbg_state}, {62'd0, MD_IDLE});
    end

    // Reset in BUSY cycle 5, late md_ready 3 cycles after that
    @(posedge clock); #1;
    dx_ir = r_ir(5'd3, 5'd1, 5'd2, ALU_MULT); data_a = 32'd7; data_b = 32'd6;
    repeat (5) begin
      @(posedge clock); #1;
    end
    check("busy5_state", {62'd0, dbg_state}, {62'd0, MD_BUSY});
    reset_n = 1'b0;
    dx_ir = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      md_ready = (c == 2);
      md_result = 32'd42;
      @(negedge clock);
      check("rstmid_ctrl", {60'd0, md_ctrl_mult, md_ctrl_div, pw_stall, pw_valid}, 64'd0);
      check("rstmid_ops", {md_op_a, md_op_b}, 64'd0);
      check("rstmid_wb", {27'd0, pw_rd, pw_data}, 64'd0);
      check("rstmid_state", {62'd0, dbg_state}, {62'd0, MD_IDLE});
      @(posedge clock); #1;
    end
    md_ready = 1'b0;

    repeat (2) @(posedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on the whole run
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Sequencer for the shared multi-cycle multiply/divide unit in the five-stage pipeline. It decodes `mult`/`div` in the D/X latch and issues a single start pulse to the unit. It waits for completion, with an optional watchdog, and drives the `pw_stall` input of the stall logic. It then hands the result, or the overflow/divide-exception status, to writeback for exactly one cycle.

## Interface
Parameters:
- `MAX_CYCLES`, 40: watchdog limit in busy cycles.
- `CNT_W`, 6: counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `dx_ir` in 32: instruction in the D/X latch.
- `data_a`, `data_b` in 32 each: bypassed operands for the D/X instruction.
- `md_ctrl_mult`, `md_ctrl_div` out 1 each: one-cycle start pulses to the unit.
- `md_op_a`, `md_op_b` out 32 each: latched operands, stable from the start pulse until completion.
- `md_result` in 32, `md_exception` in 1, `md_ready` in 1: unit completion; `md_ready` is a one-cycle pulse.
- `pw_stall` out 1: holds F/D/X while an operation is outstanding.
- `pw_valid` out 1: one-cycle writeback strobe.
- `pw_rd` out 5: destination register (30 on exception).
- `pw_data` out 32: result, or the status code on exception.

## Operation
- Decode: `md_op` is true when opcode `dx_ir[31:27]` is 00000 and ALU op `dx_ir[6:2]` is 00110 (mult) or 00111 (div).
- States are IDLE, BUSY and DONE.
- IDLE:
  - `pw_stall` = `md_op`, combinationally.
  - On `md_op`, latch `rd` = `dx_ir[26:22]`, the op type, `data_a` and `data_b`, then go to BUSY.
  - `md_ctrl_*` is registered: high during the first BUSY cycle only.
- BUSY:
  - `pw_stall` = 1.
  - The counter increments each cycle.
  - On `md_ready`, latch `md_result` and `md_exception`, then go to DONE.
- DONE:
  - `pw_stall` = 0, `pw_valid` = 1.
  - Decode is ignored for this cycle; the stalled instruction advances on this edge and must not retrigger.
  - Next state is IDLE.
- Exception output: `pw_rd` = 30; `pw_data` = 4 for mult, 5 for div.
- Normal output: `pw_rd` = latched `rd`; `pw_data` = `md_result`.
- `rd` = 0 is still sequenced; writeback discards it.
- Reset (`reset_n` = 0 at an edge): state goes to IDLE, the counter and all latched registers clear, and every output is 0.
  - A reset mid-BUSY abandons the operation.
  - A late `md_ready` arriving in IDLE is ignored.
- `md_ready` in the same cycle as the start pulse is accepted. The unit is responsible for that case.

## Timing
- `mult` in D/X at cycle t:
  - `pw_stall` is high in cycle t.
  - `md_ctrl_mult` is high in cycle t+1.
- If the unit asserts `md_ready` at cycle t+1+L, then DONE, `pw_valid` and the low `pw_stall` all fall in cycle t+2+L.
- Total stall is L+2 cycles.
- Back-to-back `mult`:
  - The second instruction enters D/X at the edge ending DONE.
  - It is decoded in the following IDLE cycle.
  - No bubble is inserted by this block.
- Outputs are registered, except `pw_stall` in IDLE.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - In BUSY, the counter reaching `MAX_CYCLES` without `md_ready` forces DONE with the exception set.
  - `pw_rd` = 30; `pw_data` = 4 or 5 by op type.
  - A `md_ready` arriving in the same cycle as the timeout wins.
- Not defined:
  - The counter and compare logic are absent.
  - BUSY waits indefinitely for `md_ready`.

## Structure
- Shared package `proc_pkg`:
  - opcode ALU = 5'b00000, ALU op MULT/DIV;
  - `RSTATUS` = 30;
  - status codes `EXC_MULT` = 4 and `EXC_DIV` = 5;
  - state enum `md_state_t`.
- Sub-module `mdop_decode`: combinational `dx_ir` to {`is_mult`, `is_div`, `rd`}. It is reused by the stall and bypass logic.

## Test plan
- `mult $3,$1,$2` with A=7, B=6 and unit latency L=17:
  - one `md_ctrl_mult` pulse;
  - `pw_stall` high for 19 cycles;
  - `pw_valid` with `pw_rd` = 3 and `pw_data` = 42.
- `div` with B=0, unit exception:
  - `pw_rd` = 30, `pw_data` = 5;
  - `md_ctrl_div` pulses exactly once.
- Back-to-back `mult` then `div`:
  - two separate start pulses;
  - exactly one `pw_valid` per operation;
  - no retrigger in the DONE cycle.
- Reset at BUSY cycle 5, then `md_ready` arriving 3 cycles later:
  - all outputs stay 0;
  - no `pw_valid`.
- With `MULTDIV_TIMEOUT_EN` and `MAX_CYCLES` = 40, `md_ready` never asserted:
  - DONE in cycle t+42;
  - `pw_rd` = 30, `pw_data` = 4 for mult.
- Non-`md_op` instructions (lw, addi, ALU add):
  - `pw_stall` stays 0;
  - no start pulses.
